// File: rtl/sm_bus_matrix_n_if.sv
// CPU data bus plus fan-out slave bus of the bus matrix.
// "slave" is the matrix's own view; "master" is the environment (CPU and peripherals).
interface sm_bus_matrix_n_if #(
    parameter int SLAVES = 4
);
    logic [31:0]          bAddr;
    logic                 bReq;
    logic                 bWrite;
    logic [31:0]          bWData;
    logic [31:0]          bRData;
    logic                 bReady;
    logic                 bErr;
    logic [SLAVES-1:0]    sSel;
    logic [31:0]          sAddr;
    logic                 sWrite;
    logic [31:0]          sWData;
    logic [SLAVES*32-1:0] sRData;
    logic [SLAVES-1:0]    sReady;

    modport master (
        output bAddr, bReq, bWrite, bWData,
        input  bRData, bReady, bErr,
        input  sSel, sAddr, sWrite, sWData,
        output sRData, sReady
    );

    modport slave (
        input  bAddr, bReq, bWrite, bWData,
        output bRData, bReady, bErr,
        output sSel, sAddr, sWrite, sWData,
        input  sRData, sReady
    );
endinterface

// File: rtl/sm_bus_matrix_n.sv
// Registered CPU-to-peripheral bus matrix with base/mask decode, wait-state
// handshake, access watchdog and an error-status bank raising irqErr.
//
// state  | meaning
// IDLE   | waiting for bReq; decodes and latches the request
// ACCESS | one slave selected, waiting for its sReady or the watchdog
// DONE   | one-cycle bReady pulse with bErr/bRData
module sm_bus_matrix_n #(
    parameter int                   SLAVES     = 4,
    parameter logic [SLAVES*32-1:0] ADDR_MATCH = {32'h7f20, 32'h7f10, 32'h7f00, 32'h2000},
    parameter logic [SLAVES*32-1:0] ADDR_MASK  = {32'hfff0, 32'hfff0, 32'hfff0, 32'he000},
    parameter int                   TIMEOUT    = 16,
    parameter logic [31:0]          STAT_BASE  = 32'h00007ff0
) (
    input  logic                clk,
    input  logic                rst,
    sm_bus_matrix_n_if.slave    bus,
    output logic                irqErr
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

    state_t            state, state_nxt;
    logic [SLAVES-1:0] sel_q, hit_oh;
    logic [31:0]       addr_q, wdata_q, rdata_q, erraddr_q;
    logic              write_q, err_q, irq_q;
    logic [15:0]       errcnt_q;
    logic [7:0]        cnt_q;
    logic              hit_any, stat_hit, sel_ready, timeout;
    logic              req_idle, err_evt, errclr;
    logic [31:0]       sel_rdata, stat_rdata, err_addr;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        stat_hit = (bus.bAddr[31:4] == STAT_BASE[31:4]);
        hit_oh   = '0;
        hit_any  = 1'b0;
        for (int k = SLAVES - 1; k >= 0; k--) begin
            if ((bus.bAddr & ADDR_MASK[32*k +: 32]) == ADDR_MATCH[32*k +: 32]) begin
                hit_oh    = '0;
                hit_oh[k] = 1'b1;
                hit_any   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < SLAVES; k++) begin
            if (sel_q[k]) sel_rdata = sel_rdata | bus.sRData[32*k +: 32];
        end
        sel_ready = |(bus.sReady & sel_q);
        timeout   = (cnt_q == 8'd0);
        case (bus.bAddr[3:2])
            2'd0:    stat_rdata = {16'h0000, errcnt_q};
            2'd1:    stat_rdata = erraddr_q;
            2'd2:    stat_rdata = {31'h0, irq_q};
            default: stat_rdata = '0;
        endcase
        req_idle = (state == IDLE) && bus.bReq;
        err_evt  = (req_idle && !stat_hit && !hit_any) ||
                   ((state == ACCESS) && !sel_ready && timeout);
        errclr   = req_idle && stat_hit && bus.bWrite &&
                   (bus.bAddr[3:2] == 2'd2) && bus.bWData[0];
        err_addr = (state == IDLE) ? bus.bAddr : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.bReq) state_nxt = (!stat_hit && hit_any) ? ACCESS : DONE;
            ACCESS:  if (sel_ready || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog is a down-counter loaded with TIMEOUT-1; zero means the last allowed cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            errcnt_q  <= '0;
            erraddr_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (req_idle) begin
                addr_q  <= bus.bAddr;
                write_q <= bus.bWrite;
                wdata_q <= bus.bWData;
                cnt_q   <= 8'(TIMEOUT - 1);
                err_q   <= !stat_hit && !hit_any;
                if (stat_hit) begin
                    rdata_q <= bus.bWrite ? 32'h0 : stat_rdata;
                end else begin
                    sel_q <= hit_oh;
                    if (!hit_any) rdata_q <= ERR_DATA;
                end
            end
            if (state == ACCESS) begin
                if (sel_ready) begin
                    sel_q   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= write_q ? 32'h0 : sel_rdata;
                end else if (timeout) begin
                    sel_q   <= '0;
                    err_q   <= 1'b1;
                    rdata_q <= ERR_DATA;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
            end
            if (errclr) begin
                errcnt_q <= '0;
                irq_q    <= 1'b0;
            end
            // Placed after the clear so a coincident error takes precedence.
            if (err_evt) begin
                if (errcnt_q != 16'hffff) errcnt_q <= errcnt_q + 16'd1;
                erraddr_q <= err_addr;
                irq_q     <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.bReady = (state == DONE);
        bus.bErr   = (state == DONE) && err_q;
        bus.bRData = rdata_q;
        bus.sSel   = sel_q;
        bus.sAddr  = addr_q;
        bus.sWrite = write_q;
        bus.sWData = wdata_q;
        irqErr     = irq_q;
    end
endmodule

// File: tb/tb_sm_bus_matrix_n.sv
// Bench for sm_bus_matrix_n: directed vector table, reset-abort sequence and
// randomized transactions checked against a decode/timing reference model.
module tb_sm_bus_matrix_n;
    localparam int          SLAVES  = 4;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] STAT    = 32'h00007ff0;
    localparam int          NEVER   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq_err;

    always #5 clk = ~clk;

    sm_bus_matrix_n_if #(.SLAVES(SLAVES)) bus();

    sm_bus_matrix_n #(.SLAVES(SLAVES), .TIMEOUT(TIMEOUT), .STAT_BASE(STAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .irqErr (irq_err)
    );

    // Slave map as the bench understands it, written out independently of the RTL packing.
    logic [31:0] m_match [SLAVES] = '{32'h2000, 32'h7f00, 32'h7f10, 32'h7f20};
    logic [31:0] m_mask  [SLAVES] = '{32'he000, 32'hfff0, 32'hfff0, 32'hfff0};

    int unsigned wait_cfg [SLAVES];
    logic [31:0] sdata    [SLAVES];
    int          acc_cnt  [SLAVES];
    bit          noise;

    logic [15:0] m_errcnt;
    logic [31:0] m_erraddr;
    bit          m_irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave models: slave k raises sReady after wait_cfg[k] cycles of being selected.
    always @(negedge clk) begin
        logic [SLAVES-1:0]    rdy;
        logic [SLAVES*32-1:0] rdv;
        rdy = '0;
        rdv = '0;
        for (int k = 0; k < SLAVES; k++) begin
            rdv[32*k +: 32] = sdata[k];
            if (bus.sSel[k]) begin
                rdy[k] = (acc_cnt[k] == int'(wait_cfg[k]));
                acc_cnt[k]++;
            end else begin
                acc_cnt[k] = 0;
                rdy[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        bus.sReady = rdy;
        bus.sRData = rdv;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: first-match decode, wait/timeout timing and status bank effects.
    task automatic predict(input logic [31:0] a, input bit w, input logic [31:0] d,
                           output bit e, output logic [31:0] rd, output int lat,
                           output int sc, output logic [SLAVES-1:0] sv);
        int tgt;
        tgt = -2;
        if ((a >> 4) == (STAT >> 4)) tgt = -1;
        else for (int k = 0; k < SLAVES; k++)
            if (tgt == -2 && (a & m_mask[k]) == m_match[k]) tgt = k;
        sv = '0; sc = 0; e = 1'b0; rd = 32'h0; lat = 1;
        if (tgt == -1) begin
            case (a[3:2])
                2'd0:    rd = {16'h0, m_errcnt};
                2'd1:    rd = m_erraddr;
                2'd2:    rd = {31'h0, m_irq};
                default: rd = 32'h0;
            endcase
            if (w) begin
                rd = 32'h0;
                if (a[3:2] == 2'd2 && d[0]) begin
                    m_errcnt = 16'h0;
                    m_irq    = 1'b0;
                end
            end
        end else if (tgt == -2) begin
            e = 1'b1;
        end else begin
            sv[tgt] = 1'b1;
            if (wait_cfg[tgt] < TIMEOUT) begin
                sc  = int'(wait_cfg[tgt]) + 1;
                lat = sc + 1;
                rd  = w ? 32'h0 : sdata[tgt];
            end else begin
                sc  = TIMEOUT;
                lat = TIMEOUT + 1;
                e   = 1'b1;
            end
        end
        if (e) begin
            rd = 32'hdeadbeef;
            if (m_errcnt != 16'hffff) m_errcnt = m_errcnt + 16'd1;
            m_erraddr = a;
            m_irq     = 1'b1;
        end
    endtask

    // Issues one request and observes it at negedges until bReady (bounded).
    task automatic run_txn(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                           output logic [31:0] rd, output bit er, output int lat,
                           output int selcnt, output logic [SLAVES-1:0] selv,
                           output bit stable_ok, output bit pulse_ok);
        bit done;
        @(negedge clk);
        bus.bAddr  = addr;
        bus.bWrite = wr;
        bus.bWData = wd;
        bus.bReq   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bReq   = 1'b0;
        bus.bAddr  = $urandom;
        bus.bWData = $urandom;
        lat = 0; selcnt = 0; selv = '0; stable_ok = 1'b1; done = 1'b0;
        rd = 32'h0; er = 1'b0;
        while (!done && lat < 300) begin
            lat++;
            if (bus.sSel != '0) begin
                selcnt++;
                if (selv == '0) selv = bus.sSel;
                else if (bus.sSel != selv) stable_ok = 1'b0;
                if (bus.sAddr !== addr || bus.sWrite !== wr || bus.sWData !== wd) stable_ok = 1'b0;
            end
            if (bus.bReady) begin
                done = 1'b1;
                rd   = bus.bRData;
                er   = bus.bErr;
            end else begin
                @(negedge clk);
            end
        end
        chk("txn_completes", 32'(done), 32'd1);
        @(negedge clk);
        pulse_ok = !bus.bReady;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wd;
        int unsigned wt;
        bit          e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          e_sc;
        logic [3:0]  e_sv;
        bit          e_irq;
    } vec_t;

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t        vt[$];
        logic [31:0] rd, p_rd;
        bit          er, p_e, st_ok, pl_ok, saw_ready;
        int          lat, sc, p_lat, p_sc;
        logic [SLAVES-1:0] sv, p_sv;
        int          pick;
        int unsigned wt_list[8] = '{0, 1, 2, 5, 14, 15, 16, NEVER};
        logic [31:0] a;

        vt.push_back(vec_t'{32'h2004, 1'b0, 32'h0,        0,     1'b0, 32'h12345678, 2,  1,  4'b0001, 1'b0});
        vt.push_back(vec_t'{32'h7f10, 1'b1, 32'ha5,       3,     1'b0, 32'h0,        5,  4,  4'b0100, 1'b0});
        vt.push_back(vec_t'{32'h7f24, 1'b0, 32'h0,        NEVER, 1'b1, 32'hdeadbeef, 17, 16, 4'b1000, 1'b1});
        vt.push_back(vec_t'{32'h5000, 1'b0, 32'h0,        0,     1'b1, 32'hdeadbeef, 1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ff0, 1'b0, 32'h0,        0,     1'b0, 32'h2,        1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ff4, 1'b0, 32'h0,        0,     1'b0, 32'h5000,     1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ff8, 1'b0, 32'h0,        0,     1'b0, 32'h1,        1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ffc, 1'b0, 32'h0,        0,     1'b0, 32'h0,        1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ffc, 1'b1, 32'h1,        0,     1'b0, 32'h0,        1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ff0, 1'b1, 32'h0,        0,     1'b0, 32'h0,        1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ff0, 1'b0, 32'h0,        0,     1'b0, 32'h2,        1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ff8, 1'b1, 32'h1,        0,     1'b0, 32'h0,        1,  0,  4'b0000, 1'b0});
        vt.push_back(vec_t'{32'h7ff0, 1'b0, 32'h0,        0,     1'b0, 32'h0,        1,  0,  4'b0000, 1'b0});
        vt.push_back(vec_t'{32'h7ff8, 1'b0, 32'h0,        0,     1'b0, 32'h0,        1,  0,  4'b0000, 1'b0});
        vt.push_back(vec_t'{32'h2004, 1'b0, 32'h0,        0,     1'b0, 32'h12345678, 2,  1,  4'b0001, 1'b0});
        vt.push_back(vec_t'{32'h7f00, 1'b0, 32'h0,        2,     1'b0, 32'h11110001, 4,  3,  4'b0010, 1'b0});
        vt.push_back(vec_t'{32'h7f0c, 1'b0, 32'h0,        15,    1'b0, 32'h11110001, 17, 16, 4'b0010, 1'b0});
        vt.push_back(vec_t'{32'h2000, 1'b1, 32'hdead0001, 16,    1'b1, 32'hdeadbeef, 17, 16, 4'b0001, 1'b1});
        vt.push_back(vec_t'{32'h7ff0, 1'b0, 32'h0,        0,     1'b0, 32'h1,        1,  0,  4'b0000, 1'b1});
        vt.push_back(vec_t'{32'h7ff4, 1'b0, 32'h0,        0,     1'b0, 32'h2000,     1,  0,  4'b0000, 1'b1});

        bus.bAddr = '0; bus.bReq = 1'b0; bus.bWrite = 1'b0; bus.bWData = '0;
        bus.sReady = '0; bus.sRData = '0;
        noise = 1'b0;
        sdata = '{32'h12345678, 32'h11110001, 32'h22220002, 32'h33330003};
        for (int k = 0; k < SLAVES; k++) begin wait_cfg[k] = 0; acc_cnt[k] = 0; end
        m_errcnt = '0; m_erraddr = '0; m_irq = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sSel",   32'(bus.sSel),   32'h0);
        chk("reset_bReady", 32'(bus.bReady), 32'h0);
        chk("reset_bErr",   32'(bus.bErr),   32'h0);
        chk("reset_bRData", bus.bRData,      32'h0);
        chk("reset_sAddr",  bus.sAddr,       32'h0);
        chk("reset_sWrite", 32'(bus.sWrite), 32'h0);
        chk("reset_sWData", bus.sWData,      32'h0);
        chk("reset_irqErr", 32'(irq_err),    32'h0);
        rst = 1'b0;

        foreach (vt[i]) begin
            for (int k = 0; k < SLAVES; k++) wait_cfg[k] = vt[i].wt;
            predict(vt[i].addr, vt[i].wr, vt[i].wd, p_e, p_rd, p_lat, p_sc, p_sv);
            run_txn(vt[i].addr, vt[i].wr, vt[i].wd, rd, er, lat, sc, sv, st_ok, pl_ok);
            chk($sformatf("vec%0d_rdata", i),  rd,          vt[i].e_rd);
            chk($sformatf("vec%0d_err", i),    32'(er),     32'(vt[i].e_err));
            chk($sformatf("vec%0d_lat", i),    32'(lat),    32'(vt[i].e_lat));
            chk($sformatf("vec%0d_selcyc", i), 32'(sc),     32'(vt[i].e_sc));
            chk($sformatf("vec%0d_sel", i),    32'(sv),     32'(vt[i].e_sv));
            chk($sformatf("vec%0d_stable", i), 32'(st_ok),  32'd1);
            chk($sformatf("vec%0d_pulse", i),  32'(pl_ok),  32'd1);
            chk($sformatf("vec%0d_irq", i),    32'(irq_err), 32'(vt[i].e_irq));
        end

        // Reset while slave 1 is stalled in ACCESS: access is abandoned silently.
        for (int k = 0; k < SLAVES; k++) wait_cfg[k] = NEVER;
        @(negedge clk);
        bus.bAddr = 32'h7f04; bus.bWrite = 1'b0; bus.bReq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bReq = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_sel_before", 32'(bus.sSel), 32'b0010);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_sel_after", 32'(bus.sSel),   32'h0);
        chk("rst_mid_bready",    32'(bus.bReady), 32'h0);
        chk("rst_mid_irq",       32'(irq_err),    32'h0);
        rst = 1'b0;
        saw_ready = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.bReady || bus.sSel != '0) saw_ready = 1'b1;
        end
        chk("rst_mid_no_pulse", 32'(saw_ready), 32'h0);
        m_errcnt = '0; m_erraddr = '0; m_irq = 1'b0;
        for (int k = 0; k < SLAVES; k++) wait_cfg[k] = 1;
        predict(32'h7f08, 1'b0, 32'h0, p_e, p_rd, p_lat, p_sc, p_sv);
        run_txn(32'h7f08, 1'b0, 32'h0, rd, er, lat, sc, sv, st_ok, pl_ok);
        chk("post_rst_rdata", rd,       p_rd);
        chk("post_rst_err",   32'(er),  32'(p_e));
        chk("post_rst_lat",   32'(lat), 32'(p_lat));
        chk("post_rst_sel",   32'(sv),  32'(p_sv));

        // Randomized traffic with noisy sReady on unselected slaves.
        noise = 1'b1;
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < SLAVES; k++) begin
                wait_cfg[k] = wt_list[$urandom_range(0, 7)];
                sdata[k]    = $urandom;
            end
            pick = $urandom_range(0, 4);
            case (pick)
                0:       a = 32'h2000 | ($urandom & 32'h1fff);
                1:       a = 32'h7f00 + $urandom_range(0, 32'h2f);
                2:       a = STAT + 32'(4 * $urandom_range(0, 3));
                3:       a = $urandom;
                default: a = 32'h7f30 + $urandom_range(0, 32'hbf);
            endcase
            er = 1'($urandom_range(0, 1));
            rd = $urandom;
            predict(a, er, rd, p_e, p_rd, p_lat, p_sc, p_sv);
            run_txn(a, er, rd, rd, er, lat, sc, sv, st_ok, pl_ok);
            chk($sformatf("rnd%0d_rdata", t),  rd,           p_rd);
            chk($sformatf("rnd%0d_err", t),    32'(er),      32'(p_e));
            chk($sformatf("rnd%0d_lat", t),    32'(lat),     32'(p_lat));
            chk($sformatf("rnd%0d_selcyc", t), 32'(sc),      32'(p_sc));
            chk($sformatf("rnd%0d_sel", t),    32'(sv),      32'(p_sv));
            chk($sformatf("rnd%0d_stable", t), 32'(st_ok),   32'd1);
            chk($sformatf("rnd%0d_pulse", t),  32'(pl_ok),   32'd1);
            chk($sformatf("rnd%0d_irq", t),    32'(irq_err), 32'(m_irq));
        end
        noise = 1'b0;

        for (int k = 0; k < SLAVES; k++) wait_cfg[k] = 0;
        predict(STAT, 1'b0, 32'h0, p_e, p_rd, p_lat, p_sc, p_sv);
        run_txn(STAT, 1'b0, 32'h0, rd, er, lat, sc, sv, st_ok, pl_ok);
        chk("final_errcnt", rd, p_rd);
        predict(STAT + 32'h4, 1'b0, 32'h0, p_e, p_rd, p_lat, p_sc, p_sv);
        run_txn(STAT + 32'h4, 1'b0, 32'h0, rd, er, lat, sc, sv, st_ok, pl_ok);
        chk("final_erraddr", rd, p_rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
